mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 178 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage access unit. Captures a load or store from EX/MEM and runs it
// against a handshaked data memory, including LDI/STI pointer indirection.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        mem_indirect_in,
  input  logic        mem_byte_in,
  input  logic [15:0] alu_out_in,
  input  logic [15:0] dest_data_in,
  input  logic        dmem_resp,
  input  logic [15:0] dmem_rdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [15:0] dmem_address,
  output logic [15:0] dmem_wdata,
  output logic [1:0]  dmem_byte_enable,
  output logic [15:0] mem_rdata_out,
  output logic        mem_done,
  output logic        stall
);

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    INDIRECT,
    ACCESS2,
    DONE
  } state_t;

  localparam logic [15:0] WORD_MASK = 16'hFFFE;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        byte_q, byte_d;
  logic        ind_q, ind_d;
  logic        done_q, done_d;

  logic        req;
  logic [15:0] load_data;

  assign req = ex_valid & (mem_read_in | mem_write_in);

  // Byte loads return the lane picked by the captured address, zero-extended.
  assign load_data = byte_q ? {8'h00, (addr_q[0] ? dmem_rdata[15:8] : dmem_rdata[7:0])}
                            : dmem_rdata;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    byte_d  = byte_q;
    ind_d   = ind_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = alu_out_in;
          data_d  = dest_data_in;
          rd_d    = mem_read_in;
          wr_d    = mem_write_in & ~mem_read_in;
          byte_d  = mem_byte_in;
          ind_d   = mem_indirect_in;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (dmem_resp) begin
          if (ind_q) begin
            ptr_d   = dmem_rdata;
            state_d = INDIRECT;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            if (rd_q) rdata_d = load_data;
          end
        end
      end
      INDIRECT: state_d = ACCESS2;
      ACCESS2: begin
        if (dmem_resp) begin
          state_d = DONE;
          done_d  = 1'b1;
          if (rd_q) rdata_d = dmem_rdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side signals decode only registered state, so they stay put while waiting.
  always_comb begin
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_address     = 16'h0000;
    dmem_wdata       = 16'h0000;
    dmem_byte_enable = 2'b00;

    case (state_q)
      ACCESS: begin
        if (ind_q) begin
          dmem_read        = 1'b1;
          dmem_address     = addr_q & WORD_MASK;
          dmem_byte_enable = 2'b11;
        end else if (byte_q) begin
          dmem_read        = rd_q;
          dmem_write       = wr_q;
          dmem_address     = addr_q;
          dmem_wdata       = {data_q[7:0], data_q[7:0]};
          dmem_byte_enable = addr_q[0] ? 2'b10 : 2'b01;
        end else begin
          dmem_read        = rd_q;
          dmem_write       = wr_q;
          dmem_address     = addr_q & WORD_MASK;
          dmem_wdata       = data_q;
          dmem_byte_enable = 2'b11;
        end
      end
      ACCESS2: begin
        dmem_read        = rd_q;
        dmem_write       = wr_q;
        dmem_address     = ptr_q & WORD_MASK;
        dmem_wdata       = data_q;
        dmem_byte_enable = 2'b11;
      end
      default: ;
    endcase
  end

  always_comb begin
    stall = 1'b1;
    if (state_q == IDLE)      stall = req;
    else if (state_q == DONE) stall = 1'b0;
  end

  assign mem_done      = done_q;
  assign mem_rdata_out = rdata_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= 16'h0000;
      data_q  <= 16'h0000;
      ptr_q   <= 16'h0000;
      rdata_q <= 16'h0000;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      byte_q  <= 1'b0;
      ind_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      byte_q  <= byte_d;
      ind_q   <= ind_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: inputs change and outputs are sampled
// on the falling clock edge, away from the rising edge the DUT acts on.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        mem_read_in = 1'b0;
  logic        mem_write_in = 1'b0;
  logic        mem_indirect_in = 1'b0;
  logic        mem_byte_in = 1'b0;
  logic [15:0] alu_out_in = 16'h0000;
  logic [15:0] dest_data_in = 16'h0000;
  logic        dmem_resp = 1'b0;
  logic [15:0] dmem_rdata = 16'h0000;
  logic        dmem_read;
  logic        dmem_write;
  logic [15:0] dmem_address;
  logic [15:0] dmem_wdata;
  logic [1:0]  dmem_byte_enable;
  logic [15:0] mem_rdata_out;
  logic        mem_done;
  logic        stall;

  int checks = 0;
  int errors = 0;

  mem_access_unit dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .ex_valid        (ex_valid),
    .mem_read_in     (mem_read_in),
    .mem_write_in    (mem_write_in),
    .mem_indirect_in (mem_indirect_in),
    .mem_byte_in     (mem_byte_in),
    .alu_out_in      (alu_out_in),
    .dest_data_in    (dest_data_in),
    .dmem_resp       (dmem_resp),
    .dmem_rdata      (dmem_rdata),
    .dmem_read       (dmem_read),
    .dmem_write      (dmem_write),
    .dmem_address    (dmem_address),
    .dmem_wdata      (dmem_wdata),
    .dmem_byte_enable(dmem_byte_enable),
    .mem_rdata_out   (mem_rdata_out),
    .mem_done        (mem_done),
    .stall           (stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_req();
    ex_valid        = 1'b0;
    mem_read_in     = 1'b0;
    mem_write_in    = 1'b0;
    mem_indirect_in = 1'b0;
    mem_byte_in     = 1'b0;
  endtask

  task automatic set_req(input logic rd, input logic wr, input logic ind, input logic byt,
                         input logic [15:0] addr, input logic [15:0] data);
    ex_valid        = 1'b1;
    mem_read_in     = rd;
    mem_write_in    = wr;
    mem_indirect_in = ind;
    mem_byte_in     = byt;
    alu_out_in      = addr;
    dest_data_in    = data;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_req();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    checks++; if (dmem_read !== 1'b0) begin errors++; $display("[TB] FAIL reset_read: got %b expected 0", dmem_read); end
    checks++; if (dmem_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_write: got %b expected 0", dmem_write); end
    checks++; if (mem_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", mem_done); end
    checks++; if (dmem_byte_enable !== 2'b00) begin errors++; $display("[TB] FAIL reset_be: got %b expected 00", dmem_byte_enable); end
    checks++; if (dmem_address !== 16'h0000) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0000", dmem_address); end
    checks++; if (dmem_wdata !== 16'h0000) begin errors++; $display("[TB] FAIL reset_wdata: got %h expected 0000", dmem_wdata); end
    checks++; if (mem_rdata_out !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0000", mem_rdata_out); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
  endtask

  task automatic test_word_load();
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 16'h3001, 16'h0000);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL wl_stall_c1: got %b expected 1", stall); end
    tick();
    clear_req();
    alu_out_in = 16'hFFFF;
    #1;
    checks++; if (dmem_read !== 1'b1) begin errors++; $display("[TB] FAIL wl_read: got %b expected 1", dmem_read); end
    checks++; if (dmem_write !== 1'b0) begin errors++; $display("[TB] FAIL wl_write: got %b expected 0", dmem_write); end
    checks++; if (dmem_address !== 16'h3000) begin errors++; $display("[TB] FAIL wl_addr: got %h expected 3000", dmem_address); end
    checks++; if (dmem_byte_enable !== 2'b11) begin errors++; $display("[TB] FAIL wl_be: got %b expected 11", dmem_byte_enable); end
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL wl_stall_c2: got %b expected 1", stall); end
    dmem_resp  = 1'b1;
    dmem_rdata = 16'hBEEF;
    tick();
    dmem_resp = 1'b0;
    checks++; if (mem_done !== 1'b1) begin errors++; $display("[TB] FAIL wl_done: got %b expected 1", mem_done); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL wl_stall_c3: got %b expected 0", stall); end
    checks++; if (dmem_read !== 1'b0) begin errors++; $display("[TB] FAIL wl_read_off: got %b expected 0", dmem_read); end
    checks++; if (mem_rdata_out !== 16'hBEEF) begin errors++; $display("[TB] FAIL wl_rdata: got %h expected BEEF", mem_rdata_out); end
    tick();
    checks++; if (mem_done !== 1'b0) begin errors++; $display("[TB] FAIL wl_done_pulse: got %b expected 0", mem_done); end
    checks++; if (mem_rdata_out !== 16'hBEEF) begin errors++; $display("[TB] FAIL wl_rdata_hold: got %h expected BEEF", mem_rdata_out); end
  endtask

  task automatic test_byte_store();
    set_req(1'b0, 1'b1, 1'b0, 1'b1, 16'h2005, 16'h12AB);
    tick();
    clear_req();
    alu_out_in   = 16'h0000;
    dest_data_in = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (dmem_write !== 1'b1) begin errors++; $display("[TB] FAIL bs_write_%0d: got %b expected 1", i, dmem_write); end
      checks++; if (dmem_read !== 1'b0) begin errors++; $display("[TB] FAIL bs_read_%0d: got %b expected 0", i, dmem_read); end
      checks++; if (dmem_byte_enable !== 2'b10) begin errors++; $display("[TB] FAIL bs_be_%0d: got %b expected 10", i, dmem_byte_enable); end
      checks++; if (dmem_wdata !== 16'hABAB) begin errors++; $display("[TB] FAIL bs_wdata_%0d: got %h expected ABAB", i, dmem_wdata); end
      checks++; if (dmem_address !== 16'h2005) begin errors++; $display("[TB] FAIL bs_addr_%0d: got %h expected 2005", i, dmem_address); end
      checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL bs_stall_%0d: got %b expected 1", i, stall); end
      if (i == 3) begin
        dmem_resp  = 1'b1;
        dmem_rdata = 16'h7E7E;
      end
      tick();
    end
    dmem_resp = 1'b0;
    checks++; if (mem_done !== 1'b1) begin errors++; $display("[TB] FAIL bs_done: got %b expected 1", mem_done); end
    checks++; if (mem_rdata_out !== 16'hBEEF) begin errors++; $display("[TB] FAIL bs_rdata_kept: got %h expected BEEF", mem_rdata_out); end
    tick();
  endtask

  task automatic test_byte_load();
    logic [15:0] addr_v [2];
    logic [1:0]  be_v [2];
    logic [15:0] exp_v [2];
    addr_v[0] = 16'h2004; be_v[0] = 2'b01; exp_v[0] = 16'h00F7;
    addr_v[1] = 16'h2007; be_v[1] = 2'b10; exp_v[1] = 16'h0080;
    for (int i = 0; i < 2; i++) begin
      set_req(1'b1, 1'b0, 1'b0, 1'b1, addr_v[i], 16'h0000);
      tick();
      clear_req();
      #1;
      checks++; if (dmem_byte_enable !== be_v[i]) begin errors++; $display("[TB] FAIL bl_be_%0d: got %b expected %b", i, dmem_byte_enable, be_v[i]); end
      checks++; if (dmem_address !== addr_v[i]) begin errors++; $display("[TB] FAIL bl_addr_%0d: got %h expected %h", i, dmem_address, addr_v[i]); end
      dmem_resp  = 1'b1;
      dmem_rdata = 16'h80F7;
      tick();
      dmem_resp = 1'b0;
      checks++; if (mem_rdata_out !== exp_v[i]) begin errors++; $display("[TB] FAIL bl_rdata_%0d: got %h expected %h", i, mem_rdata_out, exp_v[i]); end
      tick();
    end
  endtask

  task automatic test_indirect_store();
    set_req(1'b0, 1'b1, 1'b1, 1'b0, 16'h4000, 16'h1234);
    tick();
    clear_req();
    dest_data_in = 16'h0000;
    #1;
    checks++; if (dmem_read !== 1'b1) begin errors++; $display("[TB] FAIL sti_ptr_read: got %b expected 1", dmem_read); end
    checks++; if (dmem_write !== 1'b0) begin errors++; $display("[TB] FAIL sti_ptr_write: got %b expected 0", dmem_write); end
    checks++; if (dmem_address !== 16'h4000) begin errors++; $display("[TB] FAIL sti_ptr_addr: got %h expected 4000", dmem_address); end
    checks++; if (dmem_byte_enable !== 2'b11) begin errors++; $display("[TB] FAIL sti_ptr_be: got %b expected 11", dmem_byte_enable); end
    tick();
    dmem_resp  = 1'b1;
    dmem_rdata = 16'h5000;
    tick();
    dmem_rdata = 16'hDEAD;
    checks++; if (dmem_read !== 1'b0 || dmem_write !== 1'b0) begin errors++; $display("[TB] FAIL sti_ind_strobes: got %b%b expected 00", dmem_read, dmem_write); end
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL sti_ind_stall: got %b expected 1", stall); end
    checks++; if (mem_done !== 1'b0) begin errors++; $display("[TB] FAIL sti_ind_done: got %b expected 0", mem_done); end
    tick();
    checks++; if (dmem_write !== 1'b1 || dmem_read !== 1'b0) begin errors++; $display("[TB] FAIL sti_a2_strobes: got r%b w%b expected r0 w1", dmem_read, dmem_write); end
    checks++; if (dmem_address !== 16'h5000) begin errors++; $display("[TB] FAIL sti_a2_addr: got %h expected 5000", dmem_address); end
    checks++; if (dmem_wdata !== 16'h1234) begin errors++; $display("[TB] FAIL sti_a2_wdata: got %h expected 1234", dmem_wdata); end
    checks++; if (dmem_byte_enable !== 2'b11) begin errors++; $display("[TB] FAIL sti_a2_be: got %b expected 11", dmem_byte_enable); end
    tick();
    dmem_resp = 1'b0;
    checks++; if (mem_done !== 1'b1) begin errors++; $display("[TB] FAIL sti_done: got %b expected 1", mem_done); end
    checks++; if (mem_rdata_out !== 16'h0080) begin errors++; $display("[TB] FAIL sti_rdata_kept: got %h expected 0080", mem_rdata_out); end
    tick();
  endtask

  task automatic test_indirect_load();
    set_req(1'b1, 1'b0, 1'b1, 1'b0, 16'h4001, 16'h0000);
    tick();
    clear_req();
    #1;
    checks++; if (dmem_address !== 16'h4000) begin errors++; $display("[TB] FAIL ldi_ptr_addr: got %h expected 4000", dmem_address); end
    dmem_resp  = 1'b1;
    dmem_rdata = 16'h6003;
    tick();
    dmem_resp = 1'b0;
    tick();
    checks++; if (dmem_read !== 1'b1) begin errors++; $display("[TB] FAIL ldi_a2_read: got %b expected 1", dmem_read); end
    checks++; if (dmem_address !== 16'h6002) begin errors++; $display("[TB] FAIL ldi_a2_addr: got %h expected 6002", dmem_address); end
    dmem_resp  = 1'b1;
    dmem_rdata = 16'hCAFE;
    tick();
    dmem_resp = 1'b0;
    checks++; if (mem_done !== 1'b1) begin errors++; $display("[TB] FAIL ldi_done: got %b expected 1", mem_done); end
    checks++; if (mem_rdata_out !== 16'hCAFE) begin errors++; $display("[TB] FAIL ldi_rdata: got %h expected CAFE", mem_rdata_out); end
    tick();
  endtask

  task automatic test_non_memory();
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h2222);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL nm_stall_%0d: got %b expected 0", i, stall); end
      checks++; if (dmem_read !== 1'b0 || dmem_write !== 1'b0 || mem_done !== 1'b0) begin errors++; $display("[TB] FAIL nm_quiet_%0d: got r%b w%b d%b expected all 0", i, dmem_read, dmem_write, mem_done); end
      tick();
    end
    set_req(1'b1, 1'b1, 1'b0, 1'b0, 16'h1000, 16'h9999);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL rw_stall: got %b expected 1", stall); end
    tick();
    clear_req();
    #1;
    checks++; if (dmem_read !== 1'b1 || dmem_write !== 1'b0) begin errors++; $display("[TB] FAIL rw_strobes: got r%b w%b expected r1 w0", dmem_read, dmem_write); end
    dmem_resp  = 1'b1;
    dmem_rdata = 16'h4321;
    tick();
    dmem_resp = 1'b0;
    checks++; if (dmem_write !== 1'b0) begin errors++; $display("[TB] FAIL rw_write_done: got %b expected 0", dmem_write); end
    checks++; if (mem_rdata_out !== 16'h4321) begin errors++; $display("[TB] FAIL rw_rdata: got %h expected 4321", mem_rdata_out); end
    tick();
  endtask

  task automatic test_back_to_back();
    set_req(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'hA5A5);
    tick();
    clear_req();
    dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;
    checks++; if (mem_done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done1: got %b expected 1", mem_done); end
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000);
    tick();
    checks++; if (stall !== 1'b1 || dmem_read !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle: got stall%b r%b expected stall1 r0", stall, dmem_read); end
    tick();
    clear_req();
    #1;
    checks++; if (dmem_read !== 1'b1 || dmem_address !== 16'h0020) begin errors++; $display("[TB] FAIL b2b_access: got r%b addr %h expected r1 addr 0020", dmem_read, dmem_address); end
    dmem_resp  = 1'b1;
    dmem_rdata = 16'h7777;
    tick();
    dmem_resp = 1'b0;
    checks++; if (mem_rdata_out !== 16'h7777) begin errors++; $display("[TB] FAIL b2b_rdata: got %h expected 7777", mem_rdata_out); end
    tick();
  endtask

  task automatic test_reset_abort();
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 16'h3000, 16'h0000);
    tick();
    clear_req();
    tick();
    checks++; if (dmem_read !== 1'b1) begin errors++; $display("[TB] FAIL ra_waiting: got %b expected 1", dmem_read); end
    reset_n = 1'b0;
    tick();
    reset_n    = 1'b1;
    dmem_resp  = 1'b1;
    dmem_rdata = 16'h9999;
    #1;
    checks++; if (dmem_read !== 1'b0 || dmem_write !== 1'b0) begin errors++; $display("[TB] FAIL ra_strobes: got r%b w%b expected 00", dmem_read, dmem_write); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL ra_stall: got %b expected 0", stall); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (mem_done !== 1'b0) begin errors++; $display("[TB] FAIL ra_done_%0d: got %b expected 0", i, mem_done); end
      checks++; if (mem_rdata_out !== 16'h0000) begin errors++; $display("[TB] FAIL ra_rdata_%0d: got %h expected 0000", i, mem_rdata_out); end
      checks++; if (dmem_read !== 1'b0) begin errors++; $display("[TB] FAIL ra_read_%0d: got %b expected 0", i, dmem_read); end
    end
    dmem_resp = 1'b0;
  endtask

  initial begin
    $display("[TB] starting mem_access_unit bench");
    test_reset();
    test_word_load();
    test_byte_store();
    test_byte_load();
    test_indirect_store();
    test_indirect_load();
    test_non_memory();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
